// File: rtl/nx4_pkg.sv
// Shared constants, the latch report record and the rising-edge helper
// for the NX4 panel-bus receiver.
package nx4_pkg;

  localparam int NX4_CHAINS       = 12;
  localparam int NX4_DC_WIDTH     = 6;
  localparam int NX4_BITCNT_WIDTH = 11;

  typedef struct packed {
    logic [NX4_BITCNT_WIDTH-1:0] bit_count;
    logic                        mode;
    logic                        err;
  } latch_rpt_t;

  function automatic logic nx4_rise(input logic pin, input logic pin_q);
    return pin & ~pin_q;
  endfunction

endpackage

// File: rtl/nx4_panel_receiver_if.sv
// Bundle of NX4 panel pins plus the word, latch and GSCLK report outputs.
// master drives the panel pins and word_ready; slave is the receiver.
interface nx4_panel_receiver_if
  import nx4_pkg::*;
#(
  parameter int GSIDX_WIDTH = 12,
  parameter int GSCNT_WIDTH = 16
);

  logic                              led_sclk;
  logic [6:1]                        led_l_sin;
  logic [6:1]                        led_r_sin;
  logic                              led_mode;
  logic                              led_xlat;
  logic                              led_blank;
  logic                              led_gsclk;

  logic                              word_valid;
  logic                              word_ready;
  logic [NX4_CHAINS*GSIDX_WIDTH-1:0] word_data;
  logic [7:0]                        word_index;
  logic                              word_overflow;

  logic                              latch_valid;
  logic [NX4_BITCNT_WIDTH-1:0]       latch_bits;
  logic                              latch_mode;
  logic                              latch_error;

  logic                              gs_valid;
  logic [GSCNT_WIDTH-1:0]            gs_count;

  modport master (
    output led_sclk, led_l_sin, led_r_sin, led_mode, led_xlat, led_blank, led_gsclk,
    output word_ready,
    input  word_valid, word_data, word_index, word_overflow,
    input  latch_valid, latch_bits, latch_mode, latch_error,
    input  gs_valid, gs_count
  );

  modport slave (
    input  led_sclk, led_l_sin, led_r_sin, led_mode, led_xlat, led_blank, led_gsclk,
    input  word_ready,
    output word_valid, word_data, word_index, word_overflow,
    output latch_valid, latch_bits, latch_mode, latch_error,
    output gs_valid, gs_count
  );

endinterface

// File: rtl/nx4_edge_detect.sv
// Registers one strobe pin and emits a registered one-cycle pulse on the
// clock edge that first sees the pin high.
module nx4_edge_detect
  import nx4_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic rise
);

  logic pin_q;
  logic rise_r;

  // Pin history and rise pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      pin_q  <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      pin_q  <= pin;
      rise_r <= nx4_rise(pin, pin_q);
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/nx4_panel_receiver.sv
// Reference consumer of the NX4 panel bus: deserializes the 12 chains into
// word bundles, reports latch events with a length check and counts GSCLK per blank.
module nx4_panel_receiver
  import nx4_pkg::*;
#(
  parameter int GSIDX_WIDTH = 12,
  parameter int SIDX_MAX    = 576,
  parameter int GSCNT_WIDTH = 16
)(
  input  logic                 clock,
  input  logic                 reset,
  nx4_panel_receiver_if.slave  bus
);

  localparam int WBC_W = $clog2(GSIDX_WIDTH + 1);
  localparam logic [NX4_BITCNT_WIDTH-1:0] EXP_GS = NX4_BITCNT_WIDTH'(SIDX_MAX);
  localparam logic [NX4_BITCNT_WIDTH-1:0] EXP_DC = NX4_BITCNT_WIDTH'(SIDX_MAX / 2);
  localparam logic [GSIDX_WIDTH-1:0] DC_MASK =
    {{(GSIDX_WIDTH-NX4_DC_WIDTH){1'b0}}, {NX4_DC_WIDTH{1'b1}}};

  logic                              sclk_rise_s;
  logic                              xlat_rise_s;
  logic                              blank_rise_s;
  logic                              gsclk_rise_s;

  logic [6:1]                        l_sin_q;
  logic [6:1]                        r_sin_q;
  logic                              mode_q;
  logic [NX4_CHAINS-1:0]             sin_vec_s;

  logic [GSIDX_WIDTH-1:0]            shreg_r     [NX4_CHAINS];
  logic [GSIDX_WIDTH-1:0]            shreg_nxt_s [NX4_CHAINS];
  logic [NX4_BITCNT_WIDTH-1:0]       bit_cnt_r;
  logic [NX4_BITCNT_WIDTH-1:0]       bit_cnt_nxt_s;
  logic [WBC_W-1:0]                  wbits_r;
  logic [WBC_W-1:0]                  wbits_nxt_s;
  logic [WBC_W-1:0]                  wlen_s;
  logic [7:0]                        word_idx_r;
  logic                              mode_r;
  logic                              mode_cur_s;
  logic                              word_done_s;
  logic [NX4_CHAINS*GSIDX_WIDTH-1:0] word_pack_s;
  logic [NX4_BITCNT_WIDTH-1:0]       exp_bits_s;
  latch_rpt_t                        latch_nxt_s;

  logic                              word_valid_r;
  logic [NX4_CHAINS*GSIDX_WIDTH-1:0] word_data_r;
  logic [7:0]                        word_index_r;
  logic                              word_overflow_r;
  logic                              latch_valid_r;
  latch_rpt_t                        latch_r;
  logic                              gs_valid_r;
  logic [GSCNT_WIDTH-1:0]            gs_cnt_r;
  logic [GSCNT_WIDTH-1:0]            gs_count_r;

  nx4_edge_detect u_sclk_ed  (.clock(clock), .reset(reset), .pin(bus.led_sclk),  .rise(sclk_rise_s));
  nx4_edge_detect u_xlat_ed  (.clock(clock), .reset(reset), .pin(bus.led_xlat),  .rise(xlat_rise_s));
  nx4_edge_detect u_blank_ed (.clock(clock), .reset(reset), .pin(bus.led_blank), .rise(blank_rise_s));
  nx4_edge_detect u_gsclk_ed (.clock(clock), .reset(reset), .pin(bus.led_gsclk), .rise(gsclk_rise_s));

  // Data and mode pins sampled alongside the strobes so they line up with the rise pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      l_sin_q <= 6'b0;
      r_sin_q <= 6'b0;
      mode_q  <= 1'b0;
    end else begin
      l_sin_q <= bus.led_l_sin;
      r_sin_q <= bus.led_r_sin;
      mode_q  <= bus.led_mode;
    end
  end

  assign sin_vec_s = {r_sin_q, l_sin_q};

  // Shift, bit counting, mode capture and word-completion decision
  always_comb begin
    shreg_nxt_s   = shreg_r;
    bit_cnt_nxt_s = bit_cnt_r;
    wbits_nxt_s   = wbits_r;
    mode_cur_s    = mode_r;
    wlen_s        = WBC_W'(GSIDX_WIDTH);
    word_done_s   = 1'b0;
    if (sclk_rise_s) begin
      for (int i = 0; i < NX4_CHAINS; i++) begin
        shreg_nxt_s[i] = {shreg_r[i][GSIDX_WIDTH-2:0], sin_vec_s[i]};
      end
      if (bit_cnt_r == '0) mode_cur_s = mode_q;
      else                 mode_cur_s = mode_r;
      if (bit_cnt_r != '1) bit_cnt_nxt_s = bit_cnt_r + 11'd1;
      else                 bit_cnt_nxt_s = bit_cnt_r;
      if (mode_cur_s) wlen_s = WBC_W'(NX4_DC_WIDTH);
      else            wlen_s = WBC_W'(GSIDX_WIDTH);
      if (wbits_r + WBC_W'(1) == wlen_s) begin
        word_done_s = 1'b1;
        wbits_nxt_s = '0;
      end else begin
        wbits_nxt_s = wbits_r + WBC_W'(1);
      end
    end else begin
      word_done_s = 1'b0;
    end
  end

  // Right-justified bundle; dot-correction words drop the stale upper bits
  always_comb begin
    word_pack_s = '0;
    for (int i = 0; i < NX4_CHAINS; i++) begin
      if (mode_cur_s) word_pack_s[i*GSIDX_WIDTH +: GSIDX_WIDTH] = shreg_nxt_s[i] & DC_MASK;
      else            word_pack_s[i*GSIDX_WIDTH +: GSIDX_WIDTH] = shreg_nxt_s[i];
    end
  end

  // Latch report including any bit shifted on the same cycle
  always_comb begin
    if (mode_cur_s) exp_bits_s = EXP_DC;
    else            exp_bits_s = EXP_GS;
    latch_nxt_s.bit_count = bit_cnt_nxt_s;
    latch_nxt_s.mode      = mode_cur_s;
    latch_nxt_s.err       = (bit_cnt_nxt_s != exp_bits_s) || (wbits_nxt_s != '0);
  end

  // Deserializer state, output word register and latch reporting
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_r         <= '{default: '0};
      bit_cnt_r       <= '0;
      wbits_r         <= '0;
      word_idx_r      <= 8'd0;
      mode_r          <= 1'b0;
      word_valid_r    <= 1'b0;
      word_data_r     <= '0;
      word_index_r    <= 8'd0;
      word_overflow_r <= 1'b0;
      latch_valid_r   <= 1'b0;
      latch_r         <= '0;
    end else begin
      shreg_r       <= shreg_nxt_s;
      mode_r        <= mode_cur_s;
      latch_valid_r <= xlat_rise_s;
      if (xlat_rise_s) begin
        bit_cnt_r  <= '0;
        wbits_r    <= '0;
        word_idx_r <= 8'd0;
        latch_r    <= latch_nxt_s;
      end else begin
        bit_cnt_r <= bit_cnt_nxt_s;
        wbits_r   <= wbits_nxt_s;
        if (word_done_s) word_idx_r <= word_idx_r + 8'd1;
      end
      if (word_done_s && (!word_valid_r || bus.word_ready)) begin
        word_valid_r <= 1'b1;
        word_data_r  <= word_pack_s;
        word_index_r <= word_idx_r;
      end else if (word_valid_r && bus.word_ready) begin
        word_valid_r <= 1'b0;
      end
      if (word_done_s && word_valid_r && !bus.word_ready) word_overflow_r <= 1'b1;
    end
  end

  // GSCLK per blank period; a coincident gsclk edge opens the new period
  always_ff @(posedge clock) begin
    if (reset) begin
      gs_cnt_r   <= '0;
      gs_count_r <= '0;
      gs_valid_r <= 1'b0;
    end else begin
      gs_valid_r <= blank_rise_s;
      if (blank_rise_s) begin
        gs_count_r <= gs_cnt_r;
        gs_cnt_r   <= gsclk_rise_s ? GSCNT_WIDTH'(1) : '0;
      end else if (gsclk_rise_s && (gs_cnt_r != '1)) begin
        gs_cnt_r <= gs_cnt_r + GSCNT_WIDTH'(1);
      end
    end
  end

  assign bus.word_valid    = word_valid_r;
  assign bus.word_data     = word_data_r;
  assign bus.word_index    = word_index_r;
  assign bus.word_overflow = word_overflow_r;
  assign bus.latch_valid   = latch_valid_r;
  assign bus.latch_bits    = latch_r.bit_count;
  assign bus.latch_mode    = latch_r.mode;
  assign bus.latch_error   = latch_r.err;
  assign bus.gs_valid      = gs_valid_r;
  assign bus.gs_count      = gs_count_r;

endmodule

// File: doc/nx4_panel_receiver.md
# nx4_panel_receiver

Receive-side model and monitor for the Barco NX4 LED-panel serial bus. It consumes the same pins the panel driver produces (`led_sclk`, 2×6 `led_*_sin` chains, `led_mode`, `led_xlat`, `led_blank`, `led_gsclk`) in the driver's clock domain. It deserializes each chain into grayscale or dot-correction words and reports every latch event with a length check. It also measures GSCLK pulses per blank period. It sits in loopback test builds and in the verification bench as the reference consumer of the driver output.

## Interface
Parameters:
- `GSIDX_WIDTH`, 12: grayscale word width in bits.
- `SIDX_MAX`, 576: expected bits per chain per latch in grayscale mode. Dot-correction mode expects `SIDX_MAX/2`.
- `GSCNT_WIDTH`, 16: width of the GSCLK-per-blank counter.

Ports (clock and reset first):
- `clock`  in  1  single system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `led_sclk`  in  1  serial shift clock from the driver.
- `led_l_sin`  in  6  left data chains [6:1].
- `led_r_sin`  in  6  right data chains [6:1].
- `led_mode`  in  1  0 = grayscale, 1 = dot correction (6-bit words).
- `led_xlat`  in  1  latch strobe.
- `led_blank`  in  1  blank strobe.
- `led_gsclk`  in  1  grayscale PWM clock.
- `word_valid`  out  1  word bundle available.
- `word_ready`  in  1  consumer accepts the bundle.
- `word_data`  out  12×GSIDX_WIDTH  one word per chain. Order: l1..l6 then r1..r6, l1 in the LSB slice, right-justified.
- `word_index`  out  8  word number within the current latch period.
- `word_overflow`  out  1  sticky; a bundle was dropped.
- `latch_valid`  out  1  one-cycle pulse per latch.
- `latch_bits`  out  11  bits shifted since the previous latch, saturating at 2047.
- `latch_mode`  out  1  mode captured for that latch period.
- `latch_error`  out  1  qualified by `latch_valid`. Asserted if `latch_bits` differs from the expected count or a partial word was pending.
- `gs_valid`  out  1  one-cycle pulse per blank rising edge.
- `gs_count`  out  GSCNT_WIDTH  GSCLK rising edges since the previous blank rise, saturating.

## Operation
- Every input bus pin is registered once (`*_q`). A rising edge is `pin & ~pin_q` evaluated on the raw pin, so detection happens on the first clock edge that sees the pin high.
- **Sclk rise**
  - Each chain shifts in its current `sin` bit, MSB first.
  - The per-period bit counter increments.
  - The word-bit counter increments.
- **Mode capture**
  - `led_mode` is captured at the first sclk rise of a latch period (bit counter = 0) and held until the latch.
  - Word width is `GSIDX_WIDTH` when mode = 0, and 6 when mode = 1.
- **Word completion**
  - When the word-bit counter reaches the word width, the 12 shift registers are copied to the output register and `word_index` is presented.
  - The word-bit counter clears and `word_index` increments.
- **Output handshake**
  - 1-entry output register, valid/ready; transfer happens when both are high.
  - `word_valid` and `word_data` hold stable until accepted.
  - If a new word completes while `word_valid` is high and `word_ready` is low, the new word is dropped, the held word is kept, and `word_overflow` sets. It clears only on reset.
  - The driver cannot be stalled.
- **Xlat rise**
  - Emits `latch_*`.
  - Expected bit count is `SIDX_MAX` (mode 0) or `SIDX_MAX/2` (mode 1).
  - A partial word (word-bit counter ≠ 0) is discarded and forces `latch_error`.
  - The bit counter, word-bit counter and `word_index` clear.
- **Simultaneous sclk rise and xlat rise:** the bit is shifted and counted first, then the latch is reported with that bit included.
- **Xlat with zero bits:** reported with `latch_bits`=0 and `latch_error`=1.
- **Blank rise:** emits `gs_valid` with `gs_count`, then clears the counter. Simultaneous gsclk and blank rises: that gsclk edge counts toward the new period (count restarts at 1).
- **Counters:** all counters saturate and never wrap. `word_index` wraps modulo 256.

## Timing
- Reset values: `word_valid`=0, `word_data`=0, `word_index`=0, `word_overflow`=0, `latch_valid`=0, `latch_bits`=0, `latch_mode`=0, `latch_error`=0, `gs_valid`=0, `gs_count`=0.
- `word_valid` rises on the clock edge after the one that detects the final sclk rise of a word: latency 1.
- `latch_valid` and `gs_valid` pulse exactly one cycle, one cycle after edge detection. `latch_bits`, `latch_mode`, `latch_error` and `gs_count` hold until the next pulse.
- The minimum sclk period is 2 clocks (high ≥1, low ≥1). Narrower pulses are undefined.
- Reset asserted mid-word or mid-period drops all partial state.

## Structure
- Package `nx4_pkg` holds:
  - `NX4_CHAINS`=12
  - `NX4_DC_WIDTH`=6
  - `NX4_BITCNT_WIDTH`=11
  - the edge-detect helper function
- Sub-module `nx4_edge_detect`: 1-bit register plus rise pulse, instantiated for sclk, xlat, blank and gsclk.

## Test plan
- **Grayscale frame:** mode=0, 576 sclk, chain l1 carries 0xABC per word, other chains 0x000 → 48 bundles, `word_index` 0..47, `word_data[11:0]`=0xABC; xlat → `latch_bits`=576, `latch_error`=0.
- **Dot-correction frame:** mode=1, 288 sclk of 0x2A words → 48 bundles of 6-bit 0x2A; `latch_bits`=288, `latch_mode`=1, `latch_error`=0.
- **Short and partial frames:** 575 bits then xlat → `latch_bits`=575, `latch_error`=1, 47 bundles. Separately, xlat rise on the same clock edge as the 576th sclk rise → 48 bundles, `latch_bits`=576, `latch_error`=0.
- **Backpressure:** hold `word_ready`=0 across 2 words → first word held, `word_overflow`=1. Release ready → one transfer, `word_valid` drops.
- **GSCLK measurement:** 4096 gsclk pulses between blank rises → `gs_valid` with `gs_count`=4096. 70000 pulses → `gs_count`=65535.
- **Reset mid-operation:** reset after 7 bits of a word → all outputs at reset values. Next frame of 576 bits decodes cleanly from `word_index` 0.
